// File: rtl/iqft3_pkg.sv
// Shared fixed-point constants and stage configuration for the 3-qubit inverse QFT.
//
// Amplitudes are signed Q-format values with 1.0 represented as 16 (4 fraction bits).
// 1/sqrt(2) is approximated as 11. The pipeline has seven stages. The first stage
// is a one-cycle SWAP. Each of the six H/CROT stages takes ten cycles, for 61
// cycles in total.
package iqft3_pkg;

  localparam int TOTAL_WIDTH_DEF = 16;  // default signed amplitude width
  localparam int FRAC_SHIFT      = 4;   // fraction bits (1.0 = 2**FRAC_SHIFT)
  localparam int ONE_Q           = 16;  // 1.0
  localparam int INV_SQRT2_Q     = 11;  // 1/sqrt(2), also cos/sin(pi/4)
  localparam int SWAP_LAT        = 1;
  localparam int OP_LAT          = 10;
  localparam int NUM_STAGES      = 7;
  localparam int TOTAL_LAT       = SWAP_LAT + (NUM_STAGES - 1) * OP_LAT;  // 61
  localparam int N_AMP           = 8;

  typedef enum logic [1:0] {
    OP_SWAP,  // exchange q0 and q2 (index bit reversal)
    OP_H,     // Hadamard on one qubit
    OP_CROT   // controlled phase: multiply selected amplitudes by (cr, ci)
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [1:0]        qubit;  // H target qubit
    logic [7:0]        mask;   // CROT: amplitudes that receive the phase
    logic signed [7:0] cr;     // CROT constant, real part
    logic signed [7:0] ci;     // CROT constant, imaginary part
  } stage_cfg_t;

  // The seven stages in order. Stage numbers run from 1 to NUM_STAGES.
  function automatic stage_cfg_t stage_cfg(input int s);
    stage_cfg_t c;
    c = '{op: OP_SWAP, qubit: 2'd0, mask: 8'h00, cr: 8'sd0, ci: 8'sd0};
    case (s)
      2: begin c.op = OP_H; c.qubit = 2'd0; end
      3: begin  // CROT(-pi/2) q0->q1: indices 3, 7
        c.op = OP_CROT; c.mask = 8'b1000_1000; c.cr = 8'sd0; c.ci = 8'(-ONE_Q);
      end
      4: begin c.op = OP_H; c.qubit = 2'd1; end
      5: begin  // CROT(-pi/4) q0->q2: indices 5, 7
        c.op = OP_CROT; c.mask = 8'b1010_0000;
        c.cr = 8'(INV_SQRT2_Q); c.ci = 8'(-INV_SQRT2_Q);
      end
      6: begin  // CROT(-pi/2) q1->q2: indices 6, 7
        c.op = OP_CROT; c.mask = 8'b1100_0000; c.cr = 8'sd0; c.ci = 8'(-ONE_Q);
      end
      7: begin c.op = OP_H; c.qubit = 2'd2; end
      default: ;  // stage 1: SWAP
    endcase
    return c;
  endfunction

  function automatic int stage_lat(input int s);
    return (s == 1) ? SWAP_LAT : OP_LAT;
  endfunction

  // Swapping q0 and q2 reverses the three index bits.
  function automatic logic [2:0] rev_q0_q2(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/iqft3_delay_line.sv
// Fixed-depth register delay line with asynchronous active-low reset.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; clears every tap
//   d     - data in (sampled every cycle, no enable)
//   q     - data out, d delayed by DEPTH cycles
module iqft3_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  // NOTE: every tap is reset rather than only the last one, so that a reset
  // mid-flight cannot let stale vectors leak out afterwards. Non-blocking
  // assignments let the taps shift as one registered chain regardless of
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/iqft3_top_pipelined.sv
// Fully pipelined 3-qubit inverse QFT. It accepts one vector per cycle and
// applies no backpressure. The stages run in this order: SWAP(q0,q2), H(q0),
// CROT(-pi/2) q0->q1, H(q1), CROT(-pi/4) q0->q2, CROT(-pi/2) q1->q2, H(q2).
// Each stage computes all eight amplitudes combinationally from the previous
// stage. The whole 8-amplitude vector then passes through one delay line of the
// stage latency. Amplitudes that a stage does not touch therefore stay aligned
// with the amplitudes it does touch.
//
// Ports:
//   clk, rst_n           - rising-edge clock, asynchronous active-low reset
//   in_valid             - input vector present this cycle
//   iXXX_r / iXXX_i      - input amplitudes, index bits q2q1q0 (q2 = MSB)
//   out_valid            - in_valid delayed by 61 cycles
//   fXXX_r / fXXX_i      - output amplitudes after the inverse QFT
module iqft3_top_pipelined
  import iqft3_pkg::*;
#(
  parameter int TOTAL_WIDTH = TOTAL_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic signed [TOTAL_WIDTH-1:0] i000_r, i000_i, i001_r, i001_i,
  input  logic signed [TOTAL_WIDTH-1:0] i010_r, i010_i, i011_r, i011_i,
  input  logic signed [TOTAL_WIDTH-1:0] i100_r, i100_i, i101_r, i101_i,
  input  logic signed [TOTAL_WIDTH-1:0] i110_r, i110_i, i111_r, i111_i,
  output logic                          out_valid,
  output logic signed [TOTAL_WIDTH-1:0] f000_r, f000_i, f001_r, f001_i,
  output logic signed [TOTAL_WIDTH-1:0] f010_r, f010_i, f011_r, f011_i,
  output logic signed [TOTAL_WIDTH-1:0] f100_r, f100_i, f101_r, f101_i,
  output logic signed [TOTAL_WIDTH-1:0] f110_r, f110_i, f111_r, f111_i
);

  localparam int W     = TOTAL_WIDTH;
  localparam int BUS_W = 2 * N_AMP * W;  // amplitude k: real at 2k*W, imag at (2k+1)*W
  localparam int EXT_W = W + 8;          // enough headroom for (a+b)*11 and CROT sums

  typedef logic signed [W-1:0]     amp_t;
  typedef logic signed [EXT_W-1:0] ext_t;

  // Floor-divide by 2**FRAC_SHIFT, then keep the low W bits (two's-complement wrap).
  function automatic amp_t scale_trunc(input ext_t x);
    ext_t sh;
    sh = x >>> FRAC_SHIFT;
    return sh[W-1:0];
  endfunction

  function automatic amp_t h_sum(input amp_t a, input amp_t b);
    return scale_trunc((EXT_W'(a) + EXT_W'(b)) * EXT_W'(INV_SQRT2_Q));
  endfunction

  function automatic amp_t h_diff(input amp_t a, input amp_t b);
    return scale_trunc((EXT_W'(a) - EXT_W'(b)) * EXT_W'(INV_SQRT2_Q));
  endfunction

  function automatic amp_t crot_re(input amp_t ar, input amp_t ai,
                                   input logic signed [7:0] cr, input logic signed [7:0] ci);
    return scale_trunc(EXT_W'(ar) * EXT_W'(cr) - EXT_W'(ai) * EXT_W'(ci));
  endfunction

  function automatic amp_t crot_im(input amp_t ar, input amp_t ai,
                                   input logic signed [7:0] cr, input logic signed [7:0] ci);
    return scale_trunc(EXT_W'(ar) * EXT_W'(ci) + EXT_W'(ai) * EXT_W'(cr));
  endfunction

  // st_bus[0] is the raw input vector and st_bus[s] is the registered output of stage s.
  logic [BUS_W-1:0] st_bus [NUM_STAGES+1];

  assign st_bus[0] = {i111_i, i111_r, i110_i, i110_r, i101_i, i101_r, i100_i, i100_r,
                      i011_i, i011_r, i010_i, i010_r, i001_i, i001_r, i000_i, i000_r};

  for (genvar s = 1; s <= NUM_STAGES; s++) begin : g_stage
    logic [BUS_W-1:0] nxt_bus;

    // NOTE: every variable gets a value before any branch, so this block cannot
    // infer a latch.
    always_comb begin
      stage_cfg_t cfg;
      logic [2:0] kk;
      logic [2:0] p;
      amp_t cur_r [N_AMP];
      amp_t cur_i [N_AMP];
      amp_t nxt_r [N_AMP];
      amp_t nxt_i [N_AMP];
      cfg     = stage_cfg(s);
      kk      = '0;
      p       = '0;
      nxt_bus = '0;
      for (int k = 0; k < N_AMP; k++) begin
        cur_r[k] = st_bus[s-1][(2*k)*W +: W];
        cur_i[k] = st_bus[s-1][(2*k+1)*W +: W];
        nxt_r[k] = cur_r[k];
        nxt_i[k] = cur_i[k];
      end
      case (cfg.op)
        OP_SWAP: begin
          for (int k = 0; k < N_AMP; k++) begin
            p        = rev_q0_q2(3'(k));
            nxt_r[k] = cur_r[p];
            nxt_i[k] = cur_i[p];
          end
        end
        OP_H: begin
          // Visit each pair once, from the member whose target bit is 0.
          for (int k = 0; k < N_AMP; k++) begin
            kk = 3'(k);
            p  = kk | (3'b001 << cfg.qubit);
            if (((kk >> cfg.qubit) & 3'b001) == 3'b000) begin
              nxt_r[kk] = h_sum(cur_r[kk], cur_r[p]);
              nxt_i[kk] = h_sum(cur_i[kk], cur_i[p]);
              nxt_r[p]  = h_diff(cur_r[kk], cur_r[p]);
              nxt_i[p]  = h_diff(cur_i[kk], cur_i[p]);
            end
          end
        end
        OP_CROT: begin
          for (int k = 0; k < N_AMP; k++) begin
            if (cfg.mask[3'(k)]) begin
              nxt_r[k] = crot_re(cur_r[k], cur_i[k], cfg.cr, cfg.ci);
              nxt_i[k] = crot_im(cur_r[k], cur_i[k], cfg.cr, cfg.ci);
            end
          end
        end
        default: ;
      endcase
      for (int k = 0; k < N_AMP; k++) begin
        nxt_bus[(2*k)*W +: W]   = nxt_r[k];
        nxt_bus[(2*k+1)*W +: W] = nxt_i[k];
      end
    end

    iqft3_delay_line #(
      .DEPTH(stage_lat(s)),
      .WIDTH(BUS_W)
    ) u_stage_dly (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (nxt_bus),
      .q    (st_bus[s])
    );
  end

  iqft3_delay_line #(
    .DEPTH(TOTAL_LAT),
    .WIDTH(1)
  ) u_valid_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (in_valid),
    .q    (out_valid)
  );

  assign f000_r = st_bus[NUM_STAGES][ 0*W +: W];
  assign f000_i = st_bus[NUM_STAGES][ 1*W +: W];
  assign f001_r = st_bus[NUM_STAGES][ 2*W +: W];
  assign f001_i = st_bus[NUM_STAGES][ 3*W +: W];
  assign f010_r = st_bus[NUM_STAGES][ 4*W +: W];
  assign f010_i = st_bus[NUM_STAGES][ 5*W +: W];
  assign f011_r = st_bus[NUM_STAGES][ 6*W +: W];
  assign f011_i = st_bus[NUM_STAGES][ 7*W +: W];
  assign f100_r = st_bus[NUM_STAGES][ 8*W +: W];
  assign f100_i = st_bus[NUM_STAGES][ 9*W +: W];
  assign f101_r = st_bus[NUM_STAGES][10*W +: W];
  assign f101_i = st_bus[NUM_STAGES][11*W +: W];
  assign f110_r = st_bus[NUM_STAGES][12*W +: W];
  assign f110_i = st_bus[NUM_STAGES][13*W +: W];
  assign f111_r = st_bus[NUM_STAGES][14*W +: W];
  assign f111_i = st_bus[NUM_STAGES][15*W +: W];

endmodule

// File: tb/tb_iqft3_top_pipelined.sv
// Scoreboard bench for iqft3_top_pipelined (TOTAL_WIDTH = 16).
// The stimulus pushes each expected output vector into a queue. A negedge
// monitor pops an entry and compares it whenever out_valid is high. The
// monitor also checks out_valid every cycle against in_valid sampled 61
// edges earlier.
module tb_iqft3_top_pipelined;

  localparam int W   = 16;
  localparam int LAT = 61;
  localparam int VW  = 16 * W;

  typedef logic signed [W-1:0] amp_t;
  typedef struct {
    logic          chk;   // 0: data is don't-care, only the count matters
    logic [VW-1:0] data;
    string         name;
  } exp_t;

  logic clk;
  logic rst_n;
  logic in_valid;
  amp_t in_r [8];
  amp_t in_i [8];
  logic out_valid;
  amp_t out_r [8];
  amp_t out_i [8];

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [LAT-1:0] hist;

  iqft3_top_pipelined #(.TOTAL_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .i000_r(in_r[0]), .i000_i(in_i[0]), .i001_r(in_r[1]), .i001_i(in_i[1]),
    .i010_r(in_r[2]), .i010_i(in_i[2]), .i011_r(in_r[3]), .i011_i(in_i[3]),
    .i100_r(in_r[4]), .i100_i(in_i[4]), .i101_r(in_r[5]), .i101_i(in_i[5]),
    .i110_r(in_r[6]), .i110_i(in_i[6]), .i111_r(in_r[7]), .i111_i(in_i[7]),
    .out_valid(out_valid),
    .f000_r(out_r[0]), .f000_i(out_i[0]), .f001_r(out_r[1]), .f001_i(out_i[1]),
    .f010_r(out_r[2]), .f010_i(out_i[2]), .f011_r(out_r[3]), .f011_i(out_i[3]),
    .f100_r(out_r[4]), .f100_i(out_i[4]), .f101_r(out_r[5]), .f101_i(out_i[5]),
    .f110_r(out_r[6]), .f110_i(out_i[6]), .f111_r(out_r[7]), .f111_i(out_i[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [VW-1:0] pack_ints(input int r [8], input int i [8]);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[(2*k)*W +: W]   = W'(r[k]);
      v[(2*k+1)*W +: W] = W'(i[k]);
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] pack_out();
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[(2*k)*W +: W]   = out_r[k];
      v[(2*k+1)*W +: W] = out_i[k];
    end
    return v;
  endfunction

  // The expected out_valid is in_valid as sampled on the edge 61 edges earlier.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= '0;
    else        hist <= {hist[LAT-2:0], in_valid};
  end

  // Monitor: sample half a cycle after each active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("valid_align", VW'(out_valid), VW'(hist[LAT-1]));
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", VW'(1), VW'(0));
        end else begin
          e = sb.pop_front();
          if (e.chk) check(e.name, pack_out(), e.data);
        end
      end
    end
  end

  // Drive one cycle of input. A vector with valid=1 pushes its expectation.
  task automatic drive(input logic v, input int r [8], input int i [8],
                       input logic chk, input logic [VW-1:0] want, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    for (int k = 0; k < 8; k++) begin
      in_r[k] = amp_t'(r[k]);
      in_i[k] = amp_t'(i[k]);
    end
    if (v) begin
      e.chk  = chk;
      e.data = want;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    int z [8];
    z = '{0, 0, 0, 0, 0, 0, 0, 0};
    repeat (n) drive(1'b0, z, z, 1'b0, '0, "idle");
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain", VW'(sb.size()), VW'(0));
  endtask

  initial begin
    int z [8], vr [8], vi [8], er [8], ei [8];
    z = '{0, 0, 0, 0, 0, 0, 0, 0};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin in_r[k] = '0; in_i[k] = '0; end

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_out_valid", VW'(out_valid), VW'(0));
    check("reset_outputs", pack_out(), '0);
    rst_n = 1'b1;

    // Basis |000>: 16 -> 11 -> 7 -> 4 on every output.
    vr = '{16, 0, 0, 0, 0, 0, 0, 0};
    er = '{4, 4, 4, 4, 4, 4, 4, 4};
    drive(1'b1, vr, z, 1'b1, pack_ints(er, z), "basis");
    idle(2);

    // Negative basis with floor rounding: -16 -> -11 -> -8 -> -6.
    vr = '{-16, 0, 0, 0, 0, 0, 0, 0};
    er = '{-6, -6, -6, -6, -6, -6, -6, -6};
    drive(1'b1, vr, z, 1'b1, pack_ints(er, z), "neg_basis");
    idle(1);

    // Back-to-back vectors.
    vr = '{16, 0, 0, 0, 0, 0, 0, 0};
    er = '{4, 4, 4, 4, 4, 4, 4, 4};
    drive(1'b1, vr, z, 1'b1, pack_ints(er, z), "b2b_first");
    vr = '{-16, 0, 0, 0, 0, 0, 0, 0};
    er = '{-6, -6, -6, -6, -6, -6, -6, -6};
    drive(1'b1, vr, z, 1'b1, pack_ints(er, z), "b2b_second");
    idle(1);

    // Imaginary path only.
    vi = '{16, 0, 0, 0, 0, 0, 0, 0};
    ei = '{4, 4, 4, 4, 4, 4, 4, 4};
    drive(1'b1, z, vi, 1'b1, pack_ints(z, ei), "imag_basis");
    idle(1);

    // Wrap: after the swap, amplitudes 0 and 1 are both 32767.
    // H(q0) gives 720874>>>4 = 45054, which wraps to -20482.
    // H(q1) then gives -14082 and H(q2) gives -9682 on even indices.
    vr = '{32767, 0, 0, 0, 32767, 0, 0, 0};
    er = '{-9682, 0, -9682, 0, -9682, 0, -9682, 0};
    drive(1'b1, vr, z, 1'b1, pack_ints(er, z), "wrap");
    idle(1);

    // Round trip: the forward QFT of |101> at amplitude 6, phases 225*k degrees.
    // Hand-traced through all seven stages: index 101 ends at 15 and the rest
    // stay within 1 LSB.
    vr = '{6, -4, 0, 4, -6, 4, 0, -4};
    vi = '{0, -4, 6, -4, 0, 4, -6, 4};
    er = '{0, -1, 0, -1, 0, 15, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0, -1};
    drive(1'b1, vr, vi, 1'b1, pack_ints(er, ei), "round_trip_101");
    idle(1);
    wait_drain(200);

    // Random in_valid pattern with random data. Only timing is checked here.
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < 8; k++) begin
        vr[k] = int'($urandom_range(0, 65535)) - 32768;
        vi[k] = int'($urandom_range(0, 65535)) - 32768;
      end
      drive(1'($urandom_range(0, 1)), vr, vi, 1'b0, '0, "random");
    end
    idle(1);
    wait_drain(200);

    // Reset mid-flight: a pulse, then reset at cycle 30 for 3 cycles.
    vr = '{16, 0, 0, 0, 0, 0, 0, 0};
    drive(1'b1, vr, z, 1'b1, pack_ints(z, z), "flushed");
    idle(29);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    check("midreset_outputs", pack_out(), '0);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("post_reset_no_valid", VW'(out_valid), VW'(0));
      check("post_reset_zero", pack_out(), '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
